pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard / stall / flush controller for a 5-stage in-order pipe
//              (F, D, E, M, W).
//
// Purpose
//   Generates per-stage STALL (hold input latch) and FLUSH (clear input latch)
//   strobes from the current controller state and the live pipeline inputs.
//   Three hazards are resolved with fixed priority:
//     W  memory wait  (M_MEM_REQ & ~M_MEM_READY)  -> freeze F..M, bubble into W
//     B  taken branch (E_VALID & E_JMP_DO)        -> squash D and E
//     L  load-use     (E load feeding a D source) -> hold F/D, bubble into E
//   A memory wait that lasts too long drives the controller into a sticky
//   ERROR state that freezes every stage until RST.
//
// Parameters
//   MEM_TIMEOUT  consecutive wait cycles (1..255) tolerated before ERROR.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   D_VALID, D_REG_S1/S2      decode-stage valid and source register indices
//   E_VALID, E_IS_LOAD,
//   E_REG_D, E_JMP_DO         execute-stage valid, load flag, dest, redirect
//   M_MEM_REQ, M_MEM_READY    memory-stage request / completion handshake
//   F..W_STALL                hold the named stage's input latch
//   F..W_FLUSH                clear the named stage's input latch
//   ERR                       sticky memory-timeout indication
//   PERF_STALL_CNT            cycles with any stall (RUN/MEM_WAIT)
//   PERF_FLUSH_CNT            RUN cycles with a taken branch
//
// Build option
//   PIPE_CTRL_PERF_EN  when defined, the two saturating 32-bit performance
//                      counters are built; otherwise both PERF ports read 0.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        D_VALID,
  input  logic [4:0]  D_REG_S1,
  input  logic [4:0]  D_REG_S2,
  input  logic        E_VALID,
  input  logic        E_IS_LOAD,
  input  logic [4:0]  E_REG_D,
  input  logic        E_JMP_DO,
  input  logic        M_MEM_REQ,
  input  logic        M_MEM_READY,
  output logic        F_STALL,
  output logic        D_STALL,
  output logic        E_STALL,
  output logic        M_STALL,
  output logic        W_STALL,
  output logic        F_FLUSH,
  output logic        D_FLUSH,
  output logic        E_FLUSH,
  output logic        M_FLUSH,
  output logic        W_FLUSH,
  output logic        ERR,
  output logic [31:0] PERF_STALL_CNT,
  output logic [31:0] PERF_FLUSH_CNT
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Stage vectors are ordered {F, D, E, M, W} from bit 4 down to bit 0.
  localparam int unsigned NSTAGE = 5;
  localparam logic [NSTAGE-1:0] STG_F = 5'b10000;
  localparam logic [NSTAGE-1:0] STG_D = 5'b01000;
  localparam logic [NSTAGE-1:0] STG_E = 5'b00100;
  localparam logic [NSTAGE-1:0] STG_M = 5'b00010;
  localparam logic [NSTAGE-1:0] STG_W = 5'b00001;
  localparam logic [NSTAGE-1:0] STG_ALL  = 5'b11111;
  localparam logic [NSTAGE-1:0] STG_NONE = 5'b00000;

  // The wait counter is compared against MEM_TIMEOUT-1 so the ERROR state is
  // entered in the same cycle the counter reaches MEM_TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        mem_wait;
  logic        branch_taken;
  logic        src_match;
  logic        load_use;

  logic [NSTAGE-1:0] stall_vec;
  logic [NSTAGE-1:0] flush_vec;
  logic              err_out;

  // ---------------------------------------------------------------------------
  // Hazard detection (purely combinational, zero latency)
  // ---------------------------------------------------------------------------
  // READY without REQ is meaningless and must not influence anything, which
  // falls out naturally because REQ gates the wait term.
  assign mem_wait     = M_MEM_REQ & ~M_MEM_READY;
  assign branch_taken = E_VALID & E_JMP_DO & ~mem_wait;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign src_match = (E_REG_D != 5'd0) &&
                     ((E_REG_D == D_REG_S1) || (E_REG_D == D_REG_S2));

  assign load_use = E_VALID & E_IS_LOAD & D_VALID & src_match &
                    ~mem_wait & ~branch_taken;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
      ST_RUN: begin
        // Counter is held at zero in RUN so every MEM_WAIT entry starts fresh.
        wait_cnt_d = 8'd0;
        if (mem_wait) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == TIMEOUT_LAST) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        // Sticky: only RST leaves this state.
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_INIT;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // RST overrides state so the reset cycle itself already flushes every stage.
  // Each branch below produces disjoint stall/flush sets, so no stage ever
  // sees STALL and FLUSH at the same time.
  always_comb begin
    stall_vec = STG_NONE;
    flush_vec = STG_NONE;
    err_out   = 1'b0;
    if (RST) begin
      flush_vec = STG_ALL;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          flush_vec = STG_ALL;
        end
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_wait) begin
            stall_vec = STG_F | STG_D | STG_E | STG_M;
            flush_vec = STG_W;
          end else if (branch_taken) begin
            flush_vec = STG_D | STG_E;
          end else if (load_use) begin
            stall_vec = STG_F | STG_D;
            flush_vec = STG_E;
          end
        end
        ST_ERROR: begin
          stall_vec = STG_ALL;
          err_out   = 1'b1;
        end
        default: begin
          flush_vec = STG_ALL;
        end
      endcase
    end
  end

  assign F_STALL = stall_vec[4];
  assign D_STALL = stall_vec[3];
  assign E_STALL = stall_vec[2];
  assign M_STALL = stall_vec[1];
  assign W_STALL = stall_vec[0];

  assign F_FLUSH = flush_vec[4];
  assign D_FLUSH = flush_vec[3];
  assign E_FLUSH = flush_vec[2];
  assign M_FLUSH = flush_vec[1];
  assign W_FLUSH = flush_vec[0];

  assign ERR = err_out;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic        active_run_wait;

  // ERROR also stalls every stage but is deliberately excluded: only stalls
  // caused by live hazards are of interest.
  assign active_run_wait = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (active_run_wait && (|stall_vec) && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    // A branch seen while still in MEM_WAIT (wait just released) is not
    // counted; only RUN-state redirects are.
    if ((state_q == ST_RUN) && branch_taken && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign PERF_STALL_CNT = perf_stall_q;
  assign PERF_FLUSH_CNT = perf_flush_q;
`else
  assign PERF_STALL_CNT = 32'd0;
  assign PERF_FLUSH_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl (MEM_TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are compared on the
// falling edge of the same cycle. Output vector order:
//   {F,D,E,M,W}_STALL, {F,D,E,M,W}_FLUSH, ERR
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        CLK;
  logic        RST;
  logic        D_VALID;
  logic [4:0]  D_REG_S1;
  logic [4:0]  D_REG_S2;
  logic        E_VALID;
  logic        E_IS_LOAD;
  logic [4:0]  E_REG_D;
  logic        E_JMP_DO;
  logic        M_MEM_REQ;
  logic        M_MEM_READY;
  logic        F_STALL, D_STALL, E_STALL, M_STALL, W_STALL;
  logic        F_FLUSH, D_FLUSH, E_FLUSH, M_FLUSH, W_FLUSH;
  logic        ERR;
  logic [31:0] PERF_STALL_CNT;
  logic [31:0] PERF_FLUSH_CNT;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected output patterns
  localparam logic [10:0] V_RST  = 11'b00000_11111_0;
  localparam logic [10:0] V_IDLE = 11'b00000_00000_0;
  localparam logic [10:0] V_WAIT = 11'b11110_00001_0;
  localparam logic [10:0] V_BR   = 11'b00000_01100_0;
  localparam logic [10:0] V_LU   = 11'b11000_00100_0;
  localparam logic [10:0] V_ERR  = 11'b11111_00000_1;

  logic [10:0] outs;
  assign outs = {F_STALL, D_STALL, E_STALL, M_STALL, W_STALL,
                 F_FLUSH, D_FLUSH, E_FLUSH, M_FLUSH, W_FLUSH, ERR};

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .D_VALID        (D_VALID),
    .D_REG_S1       (D_REG_S1),
    .D_REG_S2       (D_REG_S2),
    .E_VALID        (E_VALID),
    .E_IS_LOAD      (E_IS_LOAD),
    .E_REG_D        (E_REG_D),
    .E_JMP_DO       (E_JMP_DO),
    .M_MEM_REQ      (M_MEM_REQ),
    .M_MEM_READY    (M_MEM_READY),
    .F_STALL        (F_STALL),
    .D_STALL        (D_STALL),
    .E_STALL        (E_STALL),
    .M_STALL        (M_STALL),
    .W_STALL        (W_STALL),
    .F_FLUSH        (F_FLUSH),
    .D_FLUSH        (D_FLUSH),
    .E_FLUSH        (E_FLUSH),
    .M_FLUSH        (M_FLUSH),
    .W_FLUSH        (W_FLUSH),
    .ERR            (ERR),
    .PERF_STALL_CNT (PERF_STALL_CNT),
    .PERF_FLUSH_CNT (PERF_FLUSH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently applied inputs; compare outputs mid-cycle.
  task automatic cyc(input string tag, input logic [10:0] exp);
    @(negedge CLK);
    check(tag, {21'd0, outs}, {21'd0, exp});
    $display("t=%0t %-14s rst=%b req=%b rdy=%b ev=%b ld=%b jmp=%b out=%b", $time, tag,
             RST, M_MEM_REQ, M_MEM_READY, E_VALID, E_IS_LOAD, E_JMP_DO, outs);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    D_VALID = 1'b0; D_REG_S1 = 5'd0; D_REG_S2 = 5'd0;
    E_VALID = 1'b0; E_IS_LOAD = 1'b0; E_REG_D = 5'd0; E_JMP_DO = 1'b0;
    M_MEM_REQ = 1'b0; M_MEM_READY = 1'b0;
  endtask

  task automatic check_perf(input string tag, input int stall_exp, input int flush_exp);
    check({tag, "_pstall"}, PERF_STALL_CNT, PERF ? 32'(stall_exp) : 32'd0);
    check({tag, "_pflush"}, PERF_FLUSH_CNT, PERF ? 32'(flush_exp) : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    RST = 1'b1;

    // Reset: two cycles under RST, then INIT, then RUN idle
    cyc("rst0", V_RST);
    cyc("rst1", V_RST);
    check_perf("rst", 0, 0);
    RST = 1'b0;
    cyc("init", V_RST);
    cyc("run_idle", V_IDLE);

    // Load-use on S2, then on S1
    E_VALID = 1'b1; E_IS_LOAD = 1'b1; E_REG_D = 5'd5; D_VALID = 1'b1; D_REG_S2 = 5'd5;
    cyc("lu_s2", V_LU);
    D_REG_S2 = 5'd0; D_REG_S1 = 5'd7; E_REG_D = 5'd7;
    cyc("lu_s1", V_LU);
    // Destination x0 never creates a hazard
    E_REG_D = 5'd0; D_REG_S1 = 5'd0; D_REG_S2 = 5'd0;
    cyc("lu_x0", V_IDLE);
    // Missing qualifiers
    E_REG_D = 5'd5; D_REG_S2 = 5'd5; D_VALID = 1'b0;
    cyc("lu_dinv", V_IDLE);
    D_VALID = 1'b1; E_IS_LOAD = 1'b0;
    cyc("lu_noload", V_IDLE);
    E_IS_LOAD = 1'b1; D_REG_S2 = 5'd6;
    cyc("lu_nomatch", V_IDLE);

    // Load-use plus taken branch: branch wins
    D_REG_S2 = 5'd5; E_JMP_DO = 1'b1;
    cyc("br_over_lu", V_BR);
    E_VALID = 1'b0;
    cyc("jmp_einv", V_IDLE);

    // READY without REQ is ignored
    idle_inputs();
    M_MEM_READY = 1'b1;
    cyc("rdy_noreq", V_IDLE);

    // Memory wait: 3 cycles low READY, then READY
    M_MEM_REQ = 1'b1; M_MEM_READY = 1'b0;
    cyc("wait1", V_WAIT);
    cyc("wait2", V_WAIT);
    cyc("wait3", V_WAIT);
    M_MEM_READY = 1'b1;
    cyc("wait_done", V_IDLE);
    idle_inputs();
    cyc("after_wait", V_IDLE);
    check_perf("wait", 5, 1);

    // Branch together with memory wait: wait behaviour only
    E_VALID = 1'b1; E_JMP_DO = 1'b1; M_MEM_REQ = 1'b1; M_MEM_READY = 1'b0;
    cyc("br_w", V_WAIT);
    M_MEM_READY = 1'b1;
    cyc("br_release", V_BR);
    idle_inputs();
    cyc("br_idle", V_IDLE);
    check_perf("br_w", 6, 1);

    // Timeout with MEM_TIMEOUT=4: ERROR from cycle 6 of the request
    M_MEM_REQ = 1'b1; M_MEM_READY = 1'b0;
    for (int i = 1; i <= 5; i++) cyc($sformatf("to_wait%0d", i), V_WAIT);
    for (int i = 6; i <= 8; i++) cyc($sformatf("to_err%0d", i), V_ERR);
    // Inputs are ignored in ERROR
    M_MEM_REQ = 1'b0; E_VALID = 1'b1; E_JMP_DO = 1'b1;
    cyc("err_ign1", V_ERR);
    M_MEM_READY = 1'b1; M_MEM_REQ = 1'b1;
    cyc("err_ign2", V_ERR);
    check_perf("err", 11, 1);

    // RST pulse leaves ERROR via INIT
    idle_inputs();
    RST = 1'b1;
    cyc("err_rst", V_RST);
    RST = 1'b0;
    cyc("err_init", V_RST);
    check_perf("post_rst", 0, 0);
    cyc("err_run", V_IDLE);

    // RST during MEM_WAIT abandons the wait
    M_MEM_REQ = 1'b1;
    cyc("mw_a", V_WAIT);
    cyc("mw_b", V_WAIT);
    RST = 1'b1;
    cyc("mw_rst", V_RST);
    RST = 1'b0; M_MEM_REQ = 1'b0;
    cyc("mw_init", V_RST);
    cyc("mw_run", V_IDLE);
    // Fresh wait counter after the abandoned wait: full 5 wait cycles again
    M_MEM_REQ = 1'b1;
    for (int i = 1; i <= 5; i++) cyc($sformatf("mw2_wait%0d", i), V_WAIT);
    cyc("mw2_err", V_ERR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
